// File: rtl/clock_gen_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
// Channel mode encoding matches the per-bit mode input of the top level.
package clock_gen_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int unsigned CG_NCH_DEF = 4;
    localparam int unsigned CG_W_DEF   = 32;

    typedef struct packed {
        logic clk_out;
        logic tick;
        logic pending;
    } ch_out_t;

endpackage

// File: rtl/clock_gen_ch.sv
// One divider channel: active scale/mode copy, terminal counter and
// registered square-wave / strobe outputs.
module clock_gen_ch
    import clock_gen_pkg::*;
#(
    parameter int unsigned W = CG_W_DEF
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  mode_e        i_mode,
    input  logic [W-1:0] i_scale,
    input  logic         i_sync,
    output ch_out_t      o_out
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_act_scale;
    mode_e        r_act_mode;
    logic         r_clk_out;
    logic         r_tick;
    logic         r_pending;

    logic w_zero;
    logic w_term;
    logic w_load;
    logic w_differ;

    assign w_zero   = (r_act_scale == '0);
    assign w_term   = i_en && !w_zero && (r_cnt == r_act_scale - W'(1));
    // Active copy only moves where the counter restarts, so a new divide
    // value can never truncate a half-period already in progress.
    assign w_load   = !i_en || i_sync || w_zero || w_term;
    assign w_differ = (i_scale != r_act_scale) || (i_mode != r_act_mode);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_act_scale <= '0;
            r_act_mode  <= MODE_TOGGLE;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            if (w_load) begin
                r_act_scale <= i_scale;
                r_act_mode  <= i_mode;
            end

            // sync wins over a coincident terminal, so no tick is emitted
            if (i_sync || !i_en || w_zero) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (w_term) begin
                r_cnt     <= '0;
                r_tick    <= 1'b1;
                r_clk_out <= (i_mode == MODE_PULSE) ? 1'b1 : ~r_clk_out;
            end else begin
                r_cnt  <= r_cnt + W'(1);
                r_tick <= 1'b0;
                if (r_act_mode == MODE_PULSE)
                    r_clk_out <= 1'b0;
            end

            r_pending <= i_en && !w_load && w_differ;
        end
    end

    assign o_out.clk_out = r_clk_out;
    assign o_out.tick    = r_tick;
    assign o_out.pending = r_pending;

endmodule

// File: rtl/clock_gen.sv
// NCH independent programmable clock dividers sharing clock, reset and a
// global phase-align strobe.
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int unsigned NCH = CG_NCH_DEF,
    parameter int unsigned W   = CG_W_DEF
)
(
    input  logic             cclk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   mode,
    input  logic [NCH*W-1:0] scale,
    input  logic             sync,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        ch_out_t w_out;

        clock_gen_ch #(
            .W (W)
        ) u_ch (
            .i_clk   (cclk),
            .i_rst   (rst),
            .i_en    (en[gi]),
            .i_mode  (mode_e'(mode[gi])),
            .i_scale (scale[gi*W +: W]),
            .i_sync  (sync),
            .o_out   (w_out)
        );

        assign clk_out[gi] = w_out.clk_out;
        assign tick[gi]    = w_out.tick;
        assign pending[gi] = w_out.pending;
    end

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen (NCH=2, W=8): stimulus queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_clock_gen;

    localparam logic [1:0] MN = 2'b00;
    localparam logic [1:0] M0 = 2'b01;
    localparam logic [1:0] M1 = 2'b10;
    localparam logic [1:0] MA = 2'b11;

    logic        cclk = 1'b0;
    logic        rst;
    logic [1:0]  en;
    logic [1:0]  mode;
    logic [15:0] scale;
    logic        sync;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  pending;

    typedef struct {
        int         cyc;
        string      nm;
        logic [1:0] cm, ce, tm, te, pm, pe;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    bit   flushing = 1'b0;

    clock_gen #(.NCH(2), .W(8)) dut (
        .cclk    (cclk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .scale   (scale),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 cclk = ~cclk;

    always @(posedge cclk) cyc <= cyc + 1;

    // Entries are keyed by the edge index after which the outputs apply.
    always @(negedge cclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc || flushing) begin
                n_cmp++;
                if (sb[i].cyc != cyc) begin
                    n_bad++;
                    $display("FAIL %s: due at edge %0d, examined at edge %0d", sb[i].nm, sb[i].cyc, cyc);
                end else if ((((clk_out ^ sb[i].ce) & sb[i].cm) != 2'b00) ||
                             (((tick    ^ sb[i].te) & sb[i].tm) != 2'b00) ||
                             (((pending ^ sb[i].pe) & sb[i].pm) != 2'b00)) begin
                    n_bad++;
                    $display("FAIL %s @edge %0d: got clk_out=%b tick=%b pending=%b, want clk_out=%b tick=%b pending=%b (care %b/%b/%b)",
                             sb[i].nm, cyc, clk_out, tick, pending,
                             sb[i].ce, sb[i].te, sb[i].pe, sb[i].cm, sb[i].tm, sb[i].pm);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int d, input string nm,
                        input logic [1:0] cm, input logic [1:0] ce,
                        input logic [1:0] tm, input logic [1:0] te,
                        input logic [1:0] pm, input logic [1:0] pe);
        exp_t e;
        e.cyc = cyc + d;
        e.nm  = $sformatf("%s_d%0d", nm, d);
        e.cm = cm; e.ce = ce; e.tm = tm; e.te = te; e.pm = pm; e.pe = pe;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge cclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  c0v, t0v, c1v;
        logic [5:0]  cv6, tv6;
        logic [10:0] c11, t11, p11;
        logic [4:0]  c05, t05, c15, t15;

        // reset, then reset dominating en and sync
        rst = 1'b1; en = 2'b00; mode = 2'b00; scale = 16'h0000; sync = 1'b0;
        step(2);
        push(0, "rst", MA, 2'b00, MA, 2'b00, MA, 2'b00);
        en = 2'b11; scale = {8'd5, 8'd3}; sync = 1'b1;
        step(1);
        push(0, "rst_dom", MA, 2'b00, MA, 2'b00, MA, 2'b00);

        // ch0 TOGGLE/3, ch1 PULSE/5, loaded while disabled then enabled
        rst = 1'b0; sync = 1'b0; en = 2'b00; mode = 2'b10; scale = {8'd5, 8'd3};
        step(1);
        en = 2'b11;
        c0v = 10'b1100011100; t0v = 10'b0100100100; c1v = 10'b1000010000;
        for (int d = 1; d <= 10; d++)
            push(d, "p1", MA, {c1v[d-1], c0v[d-1]}, MA, {c1v[d-1], t0v[d-1]}, MA, 2'b00);
        step(10);

        // ch1 PULSE scale 1: held high
        scale = {8'd1, 8'd3}; en = 2'b01;
        push(1, "p2_dis", M1, 2'b00, M1, 2'b00, M1, 2'b00);
        step(1);
        en = 2'b11;
        for (int d = 1; d <= 4; d++)
            push(d, "p2_hold", M1, 2'b10, M1, 2'b10, MA, 2'b00);
        step(4);
        push(0, "p2_ch0", M0, 2'b01, M0, 2'b01, M0, 2'b00);
        push(1, "p2_ch0", M0, 2'b01, M0, 2'b00, M0, 2'b00);
        push(2, "p2_ch0", M0, 2'b01, M0, 2'b00, M0, 2'b00);
        step(2);

        // sync coincident with ch0 and ch1 terminals; both restart at scale 3
        sync = 1'b1; mode = 2'b00; scale = {8'd3, 8'd3};
        push(1, "p3_sync", MA, 2'b00, MA, 2'b00, MA, 2'b00);
        step(1);
        sync = 1'b0;
        cv6 = 6'b011100; tv6 = 6'b100100;
        for (int d = 1; d <= 6; d++)
            push(d, "p3_align", MA, {2{cv6[d-1]}}, MA, {2{tv6[d-1]}}, MA, 2'b00);
        step(6);

        // ch0 reprogrammed 3 -> 7 right after a terminal
        scale = {8'd3, 8'd7};
        c11 = 11'b00111111100; t11 = 11'b01000000100; p11 = 11'b00000000011;
        for (int d = 1; d <= 11; d++)
            push(d, "p4_reprog", M0, {1'b0, c11[d-1]}, M0, {1'b0, t11[d-1]}, MA, {1'b0, p11[d-1]});
        push(3, "p4_ch1", M1, 2'b10, M1, 2'b10, MN, 2'b00);
        push(6, "p4_ch1", M1, 2'b00, M1, 2'b10, MN, 2'b00);
        step(11);

        // ch0 scale 0 while enabled (loaded via sync), then write 4
        scale = {8'd3, 8'd0}; sync = 1'b1;
        push(1, "p5_sync", MA, 2'b00, MA, 2'b00, MA, 2'b00);
        step(1);
        sync = 1'b0;
        push(1, "p5_stall", M0, 2'b00, M0, 2'b00, M0, 2'b00);
        push(2, "p5_stall", M0, 2'b00, M0, 2'b00, M0, 2'b00);
        step(2);
        scale = {8'd3, 8'd4};
        push(1, "p5_ch1", M1, 2'b10, M1, 2'b10, M1, 2'b00);
        cv6 = 6'b110000; tv6 = 6'b010000;
        for (int d = 1; d <= 6; d++)
            push(d, "p5_load4", M0, {1'b0, cv6[d-1]}, M0, {1'b0, tv6[d-1]}, M0, 2'b00);
        step(6);

        // reset mid-period together with sync, en held high through release
        rst = 1'b1; sync = 1'b1;
        push(1, "p6_rst", MA, 2'b00, MA, 2'b00, MA, 2'b00);
        step(1);
        rst = 1'b0; sync = 1'b0;
        c05 = 5'b10000; t05 = 5'b10000; c15 = 5'b11000; t15 = 5'b01000;
        for (int d = 1; d <= 5; d++)
            push(d, "p6_restart", MA, {c15[d-1], c05[d-1]}, MA, {t15[d-1], t05[d-1]}, MA, 2'b00);
        step(5);

        // disable clears outputs; pending stays low with differing inputs
        en = 2'b00; scale = {8'd3, 8'd9};
        push(1, "p7_dis", MA, 2'b00, MA, 2'b00, MA, 2'b00);
        step(1);

        // maximum scale 255 on ch0
        scale = {8'd3, 8'hFF};
        step(1);
        en = 2'b01;
        push(1,   "p8_max", M0, 2'b00, M0, 2'b00, M0, 2'b00);
        push(254, "p8_max", M0, 2'b00, M0, 2'b00, M0, 2'b00);
        push(255, "p8_max", M0, 2'b01, M0, 2'b01, M0, 2'b00);
        push(256, "p8_max", M0, 2'b01, M0, 2'b00, M0, 2'b00);
        step(256);

        @(negedge cclk); #1;
        flushing = 1'b1;
        @(negedge cclk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_gen.md
CLOCK_GEN -- requirements
Module: clock_gen

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter W, default 32: width of each channel's scale value and counter.
REQ-003 Port cclk, input, 1: single clock; all logic on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port en, input, NCH: per-channel enable.
REQ-006 Port mode, input, NCH: per-channel mode; 0 = TOGGLE (square wave), 1 = PULSE (one-cycle strobe).
REQ-007 Port scale, input, NCH*W: per-channel divide value; channel i occupies bits [i*W +: W].
REQ-008 Port sync, input, 1: phase-align strobe for all channels.
REQ-009 Port clk_out, output, NCH: divided output per channel, registered.
REQ-010 Port tick, output, NCH: one-cycle strobe at each channel terminal count, registered.
REQ-011 Port pending, output, NCH: high while the scale/mode inputs differ from the channel's active copy and the channel is enabled.

Function
REQ-012 Each channel SHALL hold active registers act_scale and act_mode, plus a W-bit counter cnt.
REQ-013 Active registers SHALL load from the inputs when the channel is disabled, at the channel's terminal cycle, or when act_scale == 0; at no other time (glitch-free reprogramming).
REQ-014 Terminal cycle: en high, act_scale != 0 and cnt == act_scale-1; next edge cnt <= 0, tick <= 1.
REQ-015 Non-terminal enabled cycle: cnt <= cnt+1, tick <= 0.
REQ-016 TOGGLE: clk_out inverts at each terminal cycle; half-period = act_scale cycles, period = 2*act_scale.
REQ-017 PULSE: clk_out equals tick (high exactly one cycle per act_scale cycles).
REQ-018 act_scale == 1: TOGGLE gives cclk/2; PULSE holds clk_out and tick high continuously.
REQ-019 act_scale == 0 while enabled: channel stalled; cnt = 0, clk_out = 0, tick = 0; a new nonzero scale is picked up next edge.
REQ-020 en low: next edge cnt <= 0, clk_out <= 0, tick <= 0; pending <= 0.
REQ-021 First terminal after en rises (inputs loaded that edge) SHALL occur act_scale cycles later; first clk_out rise at that edge.
REQ-022 sync high: every channel cnt <= 0, clk_out <= 0, tick <= 0, active registers reload; sync overrides a coincident terminal (no tick).
REQ-023 Counter SHALL never exceed act_scale-1; max scale 2^W-1 with no overflow or wrap.
REQ-024 Mode change SHALL take effect only at the load points of REQ-013; on a TOGGLE->PULSE load clk_out follows REQ-017 from that edge.
REQ-025 Channels SHALL be fully independent except for shared cclk, rst, sync.

Reset
REQ-026 rst SHALL force cnt = 0, act_scale = 0, act_mode = TOGGLE, clk_out = 0, tick = 0, pending = 0 for all channels on the next edge.
REQ-027 rst SHALL dominate sync and en; reset mid-period discards the partial count, and after release channels restart per REQ-021.

Structure
REQ-028 Package clock_gen_pkg SHALL hold the mode enum (MODE_TOGGLE = 0, MODE_PULSE = 1) and the default W and NCH constants.
REQ-029 One channel SHALL be a sub-module clock_gen_ch, instantiated NCH times by generate.

Verification
REQ-030 NCH = 2, W = 8; ch0 TOGGLE scale = 3, en at t0 -> clk_out[0] rises t0+3, falls t0+6, period 6; tick[0] at t0+3, t0+6.
REQ-031 ch1 PULSE scale = 5 -> clk_out[1] = tick[1], high 1 of every 5 cycles; scale = 1 -> held high.
REQ-032 ch0 scale changed 3 -> 7 at cnt = 0 -> pending high until the next terminal; the following half-period is 7 cycles with no short pulse.
REQ-033 sync on the same edge as a terminal -> no tick; all counters 0; channels re-aligned, with rising edges coincident for equal scales.
REQ-034 scale = 0 while enabled -> outputs low; write 4 -> first tick 4 cycles after the load.
REQ-035 rst asserted mid-period, and rst with sync high -> all outputs 0 next edge; after release the first tick is act_scale cycles after en is sampled.
